// File: rtl/interrupt_ctrl_pkg.sv
// Shared definitions for the exception/interrupt controller: cause codes,
// FSM state encoding and the default handler entry PC.
package interrupt_ctrl_pkg;

    localparam logic [2:0] CAUSE_EXT      = 3'b000;
    localparam logic [2:0] CAUSE_BADINSTR = 3'b001;
    localparam logic [2:0] CAUSE_OVF      = 3'b010;
    localparam logic [2:0] CAUSE_SYSCALL  = 3'b011;
    localparam logic [2:0] CAUSE_NONE     = 3'b100;

    localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_0080;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TAKE    = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } state_e;

    // Reserved encodings 101-111 collapse to a bad-instruction fault.
    function automatic logic [2:0] norm_cause(input logic [2:0] c);
        return (c > CAUSE_NONE) ? CAUSE_BADINSTR : c;
    endfunction

    function automatic logic is_sync_exc(input logic valid, input logic [2:0] c);
        logic [2:0] n;
        n = norm_cause(c);
        return valid && (n == CAUSE_BADINSTR || n == CAUSE_OVF || n == CAUSE_SYSCALL);
    endfunction

endpackage

// File: rtl/interrupt_ctrl_if.sv
// Step-3 pipeline to interrupt controller connection: cause/PC/eret inputs,
// IE write port, and the flush/redirect/status outputs.
interface interrupt_ctrl_if #(
    parameter int PC_W = 32
);
    logic            valid_step3;
    logic [2:0]      cause_step3;
    logic [PC_W-1:0] pc_step3;
    logic            eret_step3;
    logic            ie_wr;
    logic            ie_wdata;
    logic            interrupts_signal;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic [PC_W-1:0] epc;
    logic [2:0]      cause_reg;
    logic            ie;
    logic            in_handler;
    logic            double_fault;

    modport master (
        output valid_step3, cause_step3, pc_step3, eret_step3, ie_wr, ie_wdata,
        input  interrupts_signal, redirect, redirect_pc, epc, cause_reg, ie,
               in_handler, double_fault
    );

    modport slave (
        input  valid_step3, cause_step3, pc_step3, eret_step3, ie_wr, ie_wdata,
        output interrupts_signal, redirect, redirect_pc, epc, cause_reg, ie,
               in_handler, double_fault
    );
endinterface

// File: rtl/interrupt_ctrl_sync_ff.sv
// Multi-flop level synchroniser (sync_ff) bringing ext_irq into the clk domain.
module interrupt_ctrl_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_pipe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_pipe <= '0;
        else          sync_pipe <= {sync_pipe[STAGES-2:0], d};
    end

    assign q = sync_pipe[STAGES-1];
endmodule

// File: rtl/interrupt_ctrl.sv
// Exception/interrupt controller: latches EPC/cause from step 3, pulses a
// flush plus redirect to the handler, and returns to EPC on eret.
module interrupt_ctrl
    import interrupt_ctrl_pkg::*;
#(
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] HANDLER_ADDR = PC_W'(HANDLER_ADDR_DEFAULT),
    parameter int              SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ext_irq,
    interrupt_ctrl_if.slave bus
);
    state_e state;
    logic   irq_s;
    logic   sync_exc;
    logic   irq_pending;

    interrupt_ctrl_sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (ext_irq),
        .q       (irq_s)
    );

    assign sync_exc    = is_sync_exc(bus.valid_step3, bus.cause_step3);
    assign irq_pending = irq_s && bus.ie;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= ST_IDLE;
            bus.epc               <= '0;
            bus.cause_reg         <= CAUSE_NONE;
            bus.ie                <= 1'b0;
            bus.in_handler        <= 1'b0;
            bus.interrupts_signal <= 1'b0;
            bus.redirect          <= 1'b0;
            bus.redirect_pc       <= '0;
            bus.double_fault      <= 1'b0;
        end else begin
            bus.interrupts_signal <= 1'b0;
            bus.redirect          <= 1'b0;
            if (bus.ie_wr) bus.ie <= bus.ie_wdata;

            unique case (state)
                ST_IDLE: begin
                    // Interrupts wait for a valid slot so EPC is a real instruction PC.
                    if (sync_exc || (irq_pending && bus.valid_step3)) begin
                        state                 <= ST_TAKE;
                        bus.epc               <= bus.pc_step3;
                        bus.cause_reg         <= sync_exc ? norm_cause(bus.cause_step3) : CAUSE_EXT;
                        bus.interrupts_signal <= 1'b1;
                        bus.redirect          <= 1'b1;
                        bus.redirect_pc       <= HANDLER_ADDR;
                        bus.in_handler        <= 1'b1;
                    end
                end
                ST_TAKE: state <= ST_HANDLER;
                ST_HANDLER: begin
                    if (bus.valid_step3 && bus.eret_step3) begin
                        state                 <= ST_RETURN;
                        bus.interrupts_signal <= 1'b1;
                        bus.redirect          <= 1'b1;
                        bus.redirect_pc       <= bus.epc;
                    end else if (sync_exc) begin
                        bus.double_fault <= 1'b1;
                    end
                end
                ST_RETURN: begin
                    state          <= ST_IDLE;
                    bus.in_handler <= 1'b0;
                    bus.cause_reg  <= CAUSE_NONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_interrupt_ctrl.sv
// Self-checking bench for interrupt_ctrl: directed scenarios plus a random
// run compared against a cycle-level behavioural model.
module tb_interrupt_ctrl;
    localparam int PC_W = 32;
    localparam int SYNC = 2;
    localparam logic [31:0] HADDR = 32'h80;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ext_irq = 1'b0;
    int   checks = 0;
    int   errors = 0;

    interrupt_ctrl_if #(.PC_W(PC_W)) bus ();

    interrupt_ctrl #(.PC_W(PC_W), .HANDLER_ADDR(HADDR), .SYNC_STAGES(SYNC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ext_irq (ext_irq),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 normal, 1 entering handler, 2 in handler, 3 returning.
    int          m_mode;
    logic [SYNC-1:0] m_hist;
    logic [31:0] m_epc, m_rpc;
    logic [2:0]  m_cause;
    logic        m_ie, m_inh, m_df, m_pulse;

    task automatic model_reset();
        m_mode = 0; m_hist = '0; m_epc = 0; m_rpc = 0; m_cause = 3'd4;
        m_ie = 0; m_inh = 0; m_df = 0; m_pulse = 0;
    endtask

    task automatic model_step();
        logic irq_seen, exc;
        logic [2:0] c;
        irq_seen = m_hist[SYNC-1];
        m_hist = {m_hist[SYNC-2:0], ext_irq};
        c = (bus.cause_step3 > 3'd4) ? 3'd1 : bus.cause_step3;
        exc = bus.valid_step3 && (c == 3'd1 || c == 3'd2 || c == 3'd3);
        m_pulse = 0;
        if (m_mode == 0) begin
            if (exc || (irq_seen && m_ie && bus.valid_step3)) begin
                m_epc = bus.pc_step3; m_cause = exc ? c : 3'd0;
                m_mode = 1; m_pulse = 1; m_rpc = HADDR; m_inh = 1;
            end
        end else if (m_mode == 1) begin
            m_mode = 2;
        end else if (m_mode == 2) begin
            if (bus.valid_step3 && bus.eret_step3) begin
                m_mode = 3; m_pulse = 1; m_rpc = m_epc;
            end else if (exc) m_df = 1;
        end else begin
            m_mode = 0; m_inh = 0; m_cause = 3'd4;
        end
        if (bus.ie_wr) m_ie = bus.ie_wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] pc, input logic e);
        bus.valid_step3 = v; bus.cause_step3 = c; bus.pc_step3 = pc; bus.eret_step3 = e;
    endtask

    task automatic write_ie(input logic val);
        bus.ie_wr = 1; bus.ie_wdata = val; tick(); bus.ie_wr = 0;
    endtask

    task automatic apply_reset();
        reset_n = 0; #3; model_reset(); reset_n = 1;
    endtask

    task automatic leave_handler();
        drive(0, 3'd4, 0, 0); tick();
        drive(1, 3'd4, 32'h44, 1); tick();
        drive(0, 3'd4, 0, 0); tick();
    endtask

    task automatic test_reset();
        drive(1, 3'd2, 32'h40, 0); tick();
        drive(0, 3'd4, 0, 0);
        reset_n = 0; #1;
        checks++;
        if (bus.redirect !== 1'b0 || bus.interrupts_signal !== 1'b0 || bus.cause_reg !== 3'b100 ||
            bus.epc !== 32'h0 || bus.in_handler !== 1'b0 || bus.ie !== 1'b0 ||
            bus.redirect_pc !== 32'h0 || bus.double_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_take: redir=%b flush=%b cause=%b epc=%h inh=%b ie=%b rpc=%h df=%b, required all reset values",
                     bus.redirect, bus.interrupts_signal, bus.cause_reg, bus.epc, bus.in_handler,
                     bus.ie, bus.redirect_pc, bus.double_fault);
        end
        #2; model_reset(); reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); checks++;
            if (bus.redirect !== 1'b0) begin
                errors++; $display("FAIL reset_quiet: redirect=%b required 0", bus.redirect);
            end
        end
    endtask

    task automatic test_overflow_eret();
        drive(1, 3'd2, 32'h40, 0); tick();
        checks++;
        if (bus.interrupts_signal !== 1 || bus.redirect !== 1 || bus.redirect_pc !== 32'h80 ||
            bus.epc !== 32'h40 || bus.cause_reg !== 3'b010 || bus.in_handler !== 1) begin
            errors++;
            $display("FAIL overflow_take: flush=%b redir=%b rpc=%h epc=%h cause=%b inh=%b required 1 1 80 40 010 1",
                     bus.interrupts_signal, bus.redirect, bus.redirect_pc, bus.epc, bus.cause_reg, bus.in_handler);
        end
        drive(0, 3'd4, 0, 0); tick();
        checks++;
        if (bus.redirect !== 0) begin errors++; $display("FAIL take_one_cycle: redirect=%b required 0", bus.redirect); end
        // eret together with a fault: eret wins, no double fault
        drive(1, 3'd1, 32'h90, 1); tick();
        checks++;
        if (bus.redirect !== 1 || bus.interrupts_signal !== 1 || bus.redirect_pc !== 32'h40 || bus.double_fault !== 0) begin
            errors++;
            $display("FAIL eret_redirect: redir=%b flush=%b rpc=%h df=%b required 1 1 40 0",
                     bus.redirect, bus.interrupts_signal, bus.redirect_pc, bus.double_fault);
        end
        drive(0, 3'd4, 0, 0); tick();
        checks++;
        if (bus.in_handler !== 0 || bus.cause_reg !== 3'b100 || bus.redirect !== 0) begin
            errors++;
            $display("FAIL eret_exit: inh=%b cause=%b redir=%b required 0 100 0", bus.in_handler, bus.cause_reg, bus.redirect);
        end
    endtask

    task automatic test_ext_irq();
        write_ie(1);
        ext_irq = 1; drive(1, 3'd4, 32'h100, 0);
        for (int i = 0; i < SYNC; i++) begin
            tick(); checks++;
            if (bus.redirect !== 0) begin errors++; $display("FAIL irq_sync_delay[%0d]: redirect=%b required 0", i, bus.redirect); end
        end
        tick(); checks++;
        if (bus.redirect !== 1 || bus.redirect_pc !== 32'h80 || bus.cause_reg !== 3'b000 || bus.epc !== 32'h100) begin
            errors++;
            $display("FAIL irq_take: redir=%b rpc=%h cause=%b epc=%h required 1 80 000 100",
                     bus.redirect, bus.redirect_pc, bus.cause_reg, bus.epc);
        end
        ext_irq = 0;
        leave_handler();
        for (int i = 0; i < SYNC; i++) tick();
    endtask

    task automatic test_ie_off();
        write_ie(0);
        ext_irq = 1; drive(1, 3'd4, 32'h120, 0);
        for (int i = 0; i < 6; i++) begin
            tick(); checks++;
            if (bus.redirect !== 0 || bus.interrupts_signal !== 0) begin
                errors++; $display("FAIL irq_ie_off[%0d]: redir=%b flush=%b required 0 0", i, bus.redirect, bus.interrupts_signal);
            end
        end
        ext_irq = 0; drive(0, 3'd4, 0, 0);
        for (int i = 0; i < SYNC; i++) tick();
    endtask

    task automatic test_priority_double_fault();
        write_ie(1);
        ext_irq = 1; drive(0, 3'd4, 0, 0);
        for (int i = 0; i < SYNC + 1; i++) tick();
        drive(1, 3'd3, 32'h200, 0); tick();
        checks++;
        if (bus.cause_reg !== 3'b011 || bus.epc !== 32'h200 || bus.redirect !== 1) begin
            errors++; $display("FAIL priority: cause=%b epc=%h redir=%b required 011 200 1", bus.cause_reg, bus.epc, bus.redirect);
        end
        drive(1, 3'd4, 32'h80, 0); tick(); tick();
        checks++;
        if (bus.interrupts_signal !== 0) begin errors++; $display("FAIL irq_masked: flush=%b required 0", bus.interrupts_signal); end
        drive(1, 3'd1, 32'h84, 0); tick();
        checks++;
        if (bus.double_fault !== 1 || bus.epc !== 32'h200 || bus.cause_reg !== 3'b011) begin
            errors++; $display("FAIL double_fault: df=%b epc=%h cause=%b required 1 200 011", bus.double_fault, bus.epc, bus.cause_reg);
        end
        drive(1, 3'd4, 32'h88, 1); tick();
        checks++;
        if (bus.redirect_pc !== 32'h200 || bus.redirect !== 1) begin
            errors++; $display("FAIL priority_eret: rpc=%h redir=%b required 200 1", bus.redirect_pc, bus.redirect);
        end
        drive(1, 3'd4, 32'h300, 0); tick(); tick();
        checks++;
        if (bus.redirect !== 1 || bus.cause_reg !== 3'b000 || bus.epc !== 32'h300 || bus.double_fault !== 1) begin
            errors++; $display("FAIL irq_after_return: redir=%b cause=%b epc=%h df=%b required 1 000 300 1",
                               bus.redirect, bus.cause_reg, bus.epc, bus.double_fault);
        end
        ext_irq = 0;
        leave_handler();
        for (int i = 0; i < SYNC; i++) tick();
    endtask

    task automatic test_bad_cause();
        apply_reset();
        drive(1, 3'd6, 32'h500, 0); tick();
        checks++;
        if (bus.cause_reg !== 3'b001 || bus.epc !== 32'h500) begin
            errors++; $display("FAIL reserved_cause: cause=%b epc=%h required 001 500", bus.cause_reg, bus.epc);
        end
        leave_handler();
        drive(1, 3'd0, 32'h510, 0); tick();
        checks++;
        if (bus.redirect !== 0) begin errors++; $display("FAIL cause_ext_ignored: redirect=%b required 0", bus.redirect); end
        drive(1, 3'd4, 32'h520, 1); tick();
        checks++;
        if (bus.redirect !== 0) begin errors++; $display("FAIL eret_in_idle: redirect=%b required 0", bus.redirect); end
    endtask

    task automatic test_random();
        logic [2:0] c;
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            c = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd4;
            drive($urandom_range(0, 9) < 7, c, {$urandom_range(0, 255), 2'b00}, $urandom_range(0, 6) == 0);
            bus.ie_wr = ($urandom_range(0, 15) == 0); bus.ie_wdata = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0) ext_irq = ~ext_irq;
            if (n == 300) apply_reset();
            tick();
            checks++;
            if (bus.interrupts_signal !== m_pulse || bus.redirect !== m_pulse) begin
                errors++; $display("FAIL rand_pulse[%0d]: flush=%b redir=%b required %b", n, bus.interrupts_signal, bus.redirect, m_pulse);
            end
            checks++;
            if (bus.redirect_pc !== m_rpc || bus.epc !== m_epc) begin
                errors++; $display("FAIL rand_pc[%0d]: rpc=%h epc=%h required %h %h", n, bus.redirect_pc, bus.epc, m_rpc, m_epc);
            end
            checks++;
            if (bus.cause_reg !== m_cause || bus.ie !== m_ie || bus.in_handler !== m_inh || bus.double_fault !== m_df) begin
                errors++; $display("FAIL rand_status[%0d]: cause=%b ie=%b inh=%b df=%b required %b %b %b %b",
                                   n, bus.cause_reg, bus.ie, bus.in_handler, bus.double_fault, m_cause, m_ie, m_inh, m_df);
            end
        end
    endtask

    initial begin
        drive(0, 3'd4, 0, 0);
        bus.ie_wr = 0; bus.ie_wdata = 0;
        #12; model_reset(); reset_n = 1;
        test_reset();
        test_overflow_eret();
        test_ext_irq();
        test_ie_off();
        test_priority_double_fault();
        test_bad_cause();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
